// File: rtl/spi_sample_responder.sv
// SPI slave (CPOL=1, MSB first) that streams queued samples to the master on MISO.
// Build option SPI_RESPONDER_FIFO_EN: sample FIFO of FIFO_DEPTH entries; otherwise one holding register.
//
// state | meaning
// IDLE  | waiting for chipselect to fall; spi_data held at 0
// SHIFT | driving sample bits on each spi_clock falling edge
// HOLD  | all bits sent; LSB held until next spi_clock fall, then 0

module spi_sample_responder #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic [SAMPLE_WIDTH-1:0]       sample_data,
  input  logic                          sample_valid,
  output logic                          sample_ready,
  input  logic                          spi_clock,
  input  logic                          spi_chipselect,
  output logic                          spi_data,
  output logic                          frame_done,
  output logic                          underrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(SAMPLE_WIDTH + 1);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  logic [1:0]              state;
  logic [SAMPLE_WIDTH-1:0] shift_reg;
  logic [CW-1:0]           bit_count;

  logic cs_s1, cs_s2, cs_s3;
  logic sck_s1, sck_s2, sck_s3;
  logic [1:0] settle;
  logic cs_armed;

  logic cs_fall, cs_rise, sck_fall;
  logic start, fifo_empty, pop, push;
  logic [SAMPLE_WIDTH-1:0] head;

  // Synchronizers idle high so reset release never looks like an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      cs_s1  <= 1'b1;
      cs_s2  <= 1'b1;
      cs_s3  <= 1'b1;
      sck_s1 <= 1'b1;
      sck_s2 <= 1'b1;
      sck_s3 <= 1'b1;
    end else begin
      cs_s1  <= spi_chipselect;
      cs_s2  <= cs_s1;
      cs_s3  <= cs_s2;
      sck_s1 <= spi_clock;
      sck_s2 <= sck_s1;
      sck_s3 <= sck_s2;
    end
  end

  // After reset, a frame may only start once chipselect has been seen high with
  // the synchronizer flushed; a chipselect already low at release is not a new frame.
  always_ff @(posedge clock) begin
    if (reset) begin
      settle   <= 2'd0;
      cs_armed <= 1'b0;
    end else begin
      if (settle != 2'd3)
        settle <= settle + 2'd1;
      if (settle == 2'd3 && cs_s2)
        cs_armed <= 1'b1;
    end
  end

  assign cs_fall  = cs_armed & cs_s3 & ~cs_s2;
  assign cs_rise  = ~cs_s3 & cs_s2;
  assign sck_fall = sck_s3 & ~sck_s2;

  assign start      = (state == ST_IDLE) && cs_fall;
  assign fifo_empty = (fifo_level == '0);
  assign pop        = start && !fifo_empty;
  assign push       = sample_valid && sample_ready;

`ifdef SPI_RESPONDER_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [SAMPLE_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]           wr_ptr;
  logic [AW-1:0]           rd_ptr;
  logic [LW-1:0]           level;

  assign sample_ready = (level < LW'(FIFO_DEPTH));
  assign fifo_level   = level;
  assign head         = mem[rd_ptr];

  always_ff @(posedge clock) begin
    if (push)
      mem[wr_ptr] <= sample_data;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end
`else
  logic [SAMPLE_WIDTH-1:0] hold_reg;
  logic                    hold_full;

  assign sample_ready = ~hold_full;
  assign fifo_level   = {{(LW-1){1'b0}}, hold_full};
  assign head         = hold_reg;

  // push needs the register empty and pop needs it full, so they never coincide.
  always_ff @(posedge clock) begin
    if (reset) begin
      hold_reg  <= '0;
      hold_full <= 1'b0;
    end else if (push) begin
      hold_reg  <= sample_data;
      hold_full <= 1'b1;
    end else if (pop) begin
      hold_full <= 1'b0;
    end
  end
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      state      <= ST_IDLE;
      shift_reg  <= '0;
      bit_count  <= '0;
      spi_data   <= 1'b0;
      frame_done <= 1'b0;
      underrun   <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      underrun   <= 1'b0;
      case (state)
        ST_IDLE: begin
          spi_data <= 1'b0;
          if (start) begin
            shift_reg <= fifo_empty ? '0 : head;
            underrun  <= fifo_empty;
            bit_count <= '0;
            state     <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (cs_rise) begin
            spi_data <= 1'b0;
            state    <= ST_IDLE;
          end else if (sck_fall) begin
            spi_data  <= shift_reg[SAMPLE_WIDTH-1];
            shift_reg <= {shift_reg[SAMPLE_WIDTH-2:0], 1'b0};
            bit_count <= bit_count + 1'b1;
            if (bit_count == CW'(SAMPLE_WIDTH - 1))
              state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (cs_rise) begin
            frame_done <= 1'b1;
            spi_data   <= 1'b0;
            state      <= ST_IDLE;
          end else if (sck_fall) begin
            spi_data <= 1'b0;
          end
        end
        default: begin
          spi_data <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_sample_responder.sv
// Directed bench for spi_sample_responder: frame table plus latency, underrun/push race,
// build-specific queueing (SPI_RESPONDER_FIFO_EN) and mid-frame reset sequences.

module tb_spi_sample_responder;

  logic        clock = 1'b0;
  logic        reset;
  logic [15:0] sample_data;
  logic        sample_valid;
  logic        sample_ready;
  logic        spi_clock;
  logic        spi_chipselect;
  logic        spi_data;
  logic        frame_done;
  logic        underrun;
  logic [2:0]  fifo_level;

  spi_sample_responder #(.SAMPLE_WIDTH(16), .FIFO_DEPTH(4)) dut (
    .clock          (clock),
    .reset          (reset),
    .sample_data    (sample_data),
    .sample_valid   (sample_valid),
    .sample_ready   (sample_ready),
    .spi_clock      (spi_clock),
    .spi_chipselect (spi_chipselect),
    .spi_data       (spi_data),
    .frame_done     (frame_done),
    .underrun       (underrun),
    .fifo_level     (fifo_level)
  );

  always #5 clock = ~clock;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int under_cnt = 0;

  always @(negedge clock) begin
    if (frame_done) done_cnt++;
    if (underrun)   under_cnt++;
  end

  typedef struct {
    logic        do_push;
    logic [15:0] val;
    int          n_bits;
    logic [15:0] cap;
    int          done;
    int          under;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic push(input logic [15:0] v);
    sample_data  = v;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
  endtask

  // Master captures spi_data just as spi_clock rises.
  task automatic run_bits(input int n, output logic [15:0] cap);
    cap = '0;
    for (int i = 0; i < n; i++) begin
      spi_clock = 1'b0;
      cycles(8);
      cap = {cap[14:0], spi_data};
      spi_clock = 1'b1;
      cycles(8);
    end
  endtask

  task automatic frame(input int n, output logic [15:0] cap, output int d_done, output int d_under);
    int d0;
    int u0;
    d0 = done_cnt;
    u0 = under_cnt;
    spi_chipselect = 1'b0;
    cycles(8);
    run_bits(n, cap);
    spi_chipselect = 1'b1;
    cycles(8);
    d_done  = done_cnt - d0;
    d_under = under_cnt - u0;
  endtask

  initial begin
    logic [15:0] cap;
    int dd;
    int du;
    int d0;
    int u0;

    vecs[0] = '{1'b1, 16'hA5C3, 16, 16'hA5C3, 1, 0};
    vecs[1] = '{1'b0, 16'h0000, 16, 16'h0000, 1, 1};
    vecs[2] = '{1'b1, 16'hFFFF, 16, 16'hFFFF, 1, 0};
    vecs[3] = '{1'b1, 16'h0001, 16, 16'h0001, 1, 0};
    vecs[4] = '{1'b1, 16'h8000, 16, 16'h8000, 1, 0};
    vecs[5] = '{1'b1, 16'h1111,  7, 16'h0008, 0, 0};
    vecs[6] = '{1'b1, 16'h2222, 16, 16'h2222, 1, 0};
    vecs[7] = '{1'b1, 16'h3C5A, 16, 16'h3C5A, 1, 0};

    reset          = 1'b1;
    sample_data    = '0;
    sample_valid   = 1'b0;
    spi_clock      = 1'b1;
    spi_chipselect = 1'b1;
    cycles(3);
    check("rst_spi_data", 32'(spi_data), 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    check("rst_ready", 32'(sample_ready), 32'd1);
    check("rst_done", 32'(frame_done), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    cycles(8);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_push) begin
        push(vecs[i].val);
        check($sformatf("v%0d_level_before", i), 32'(fifo_level), 32'd1);
      end
      frame(vecs[i].n_bits, cap, dd, du);
      check($sformatf("v%0d_capture", i), 32'(cap), 32'(vecs[i].cap));
      check($sformatf("v%0d_frame_done", i), 32'(dd), 32'(vecs[i].done));
      check($sformatf("v%0d_underrun", i), 32'(du), 32'(vecs[i].under));
      check($sformatf("v%0d_idle_data", i), 32'(spi_data), 32'd0);
      check($sformatf("v%0d_level_after", i), 32'(fifo_level), 32'd0);
    end

    // spi_data moves exactly three clocks after a spi_clock fall; then abort after one bit.
    d0 = done_cnt;
    push(16'h8000);
    spi_chipselect = 1'b0;
    cycles(8);
    spi_clock = 1'b0;
    @(negedge clock);
    check("lat_cycle1", 32'(spi_data), 32'd0);
    @(negedge clock);
    check("lat_cycle2", 32'(spi_data), 32'd0);
    @(negedge clock);
    check("lat_cycle3", 32'(spi_data), 32'd1);
    cycles(5);
    spi_clock = 1'b1;
    cycles(8);
    spi_chipselect = 1'b1;
    cycles(8);
    check("lat_abort_done", 32'(done_cnt - d0), 32'd0);
    check("lat_abort_idle", 32'(spi_data), 32'd0);

    // Push into an empty queue in the same cycle the frame starts: underrun, sample kept.
    d0 = done_cnt;
    spi_chipselect = 1'b0;
    @(negedge clock);
    @(negedge clock);
    sample_data  = 16'hBEEF;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    check("race_underrun", 32'(underrun), 32'd1);
    check("race_level", 32'(fifo_level), 32'd1);
    cycles(5);
    run_bits(16, cap);
    spi_chipselect = 1'b1;
    cycles(8);
    check("race_capture", 32'(cap), 32'h0000);
    check("race_done", 32'(done_cnt - d0), 32'd1);
    frame(16, cap, dd, du);
    check("race_kept_capture", 32'(cap), 32'hBEEF);
    check("race_kept_underrun", 32'(du), 32'd0);

`ifdef SPI_RESPONDER_FIFO_EN
    sample_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sample_data = 16'(i);
      @(negedge clock);
    end
    sample_valid = 1'b0;
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_ready", 32'(sample_ready), 32'd0);
    for (int k = 0; k < 4; k++) begin
      frame(16, cap, dd, du);
      check($sformatf("fifo_order%0d", k), 32'(cap), 32'(k + 1));
    end
    check("drained_level", 32'(fifo_level), 32'd0);

    // Push coinciding with a pop on a non-empty FIFO keeps level and order.
    push(16'h0A0A);
    spi_chipselect = 1'b0;
    @(negedge clock);
    @(negedge clock);
    sample_data  = 16'h0B0B;
    sample_valid = 1'b1;
    @(negedge clock);
    sample_valid = 1'b0;
    check("pushpop_level", 32'(fifo_level), 32'd1);
    cycles(5);
    run_bits(16, cap);
    spi_chipselect = 1'b1;
    cycles(8);
    check("pushpop_first", 32'(cap), 32'h0A0A);
    frame(16, cap, dd, du);
    check("pushpop_second", 32'(cap), 32'h0B0B);
`else
    push(16'hAAAA);
    check("single_ready", 32'(sample_ready), 32'd0);
    push(16'hBBBB);
    check("single_level", 32'(fifo_level), 32'd1);
    frame(16, cap, dd, du);
    check("single_capture", 32'(cap), 32'hAAAA);
    check("single_empty_ready", 32'(sample_ready), 32'd1);
`endif

    // Reset during bit 10 with chipselect still low at release.
    d0 = done_cnt;
    push(16'h0F0F);
    spi_chipselect = 1'b0;
    cycles(8);
    run_bits(9, cap);
    spi_clock = 1'b0;
    cycles(4);
    reset = 1'b1;
    @(negedge clock);
    check("midrst_spi_data", 32'(spi_data), 32'd0);
    check("midrst_level", 32'(fifo_level), 32'd0);
    check("midrst_ready", 32'(sample_ready), 32'd1);
    check("midrst_done", 32'(frame_done), 32'd0);
    check("midrst_underrun", 32'(underrun), 32'd0);
    reset = 1'b0;
    u0 = under_cnt;
    cycles(4);
    spi_clock = 1'b1;
    cycles(8);
    run_bits(4, cap);
    check("postrst_no_frame_data", 32'(cap), 32'd0);
    check("postrst_no_underrun", 32'(under_cnt - u0), 32'd0);
    spi_chipselect = 1'b1;
    cycles(8);
    check("postrst_no_done", 32'(done_cnt - d0), 32'd0);
    push(16'h1234);
    frame(16, cap, dd, du);
    check("postrst_capture", 32'(cap), 32'h1234);
    check("postrst_done", 32'(dd), 32'd1);
    check("postrst_underrun", 32'(du), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
